// File: rtl/clock_splitter_pkg.sv
// Shared constants and helpers for the slow-clock divider.
// Keeps the legal parameter range and counter sizing in one place.
package clock_splitter_pkg;

    localparam int unsigned HALF_PERIOD_MAX = 65535;

    // $clog2 of 1 is 0, but the counter always needs at least one bit.
    function automatic int unsigned cnt_width(input int unsigned half_period);
        return (half_period > 1) ? $clog2(half_period) : 1;
    endfunction

endpackage

// File: rtl/clock_splitter.sv
// Divides CLK to a 50 %-duty slowCLK and emits one-cycle rise/fall strobes
// so downstream logic can stay on CLK and use clock enables.
module clock_splitter
    import clock_splitter_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic CLK,
    input  logic reset,
    output logic slowCLK,
    output logic slow_rise,
    output logic slow_fall
);

    localparam int unsigned CNT_W = cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    if (HALF_PERIOD == 0 || HALF_PERIOD > HALF_PERIOD_MAX) begin : g_bad_half_period
        $error("clock_splitter: HALF_PERIOD must be in 1..65535");
    end

    logic [CNT_W-1:0] cnt;

    // Strobes are loaded from the pre-toggle value so they coincide with the
    // first cycle of the new slowCLK level; all outputs are plain flops.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt       <= '0;
            slowCLK   <= 1'b0;
            slow_rise <= 1'b0;
            slow_fall <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            slowCLK   <= ~slowCLK;
            slow_rise <= ~slowCLK;
            slow_fall <= slowCLK;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            slow_rise <= 1'b0;
            slow_fall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_splitter.sv
// Directed bench for clock_splitter at HALF_PERIOD = 1, 3, 4 and 5.
// Outputs are sampled on the falling edge of CLK.
module tb_clock_splitter;

    logic CLK = 1'b0;
    logic reset = 1'b1;

    logic s1, r1, f1;
    logic s3, r3, f3;
    logic s4, r4, f4;
    logic s5, r5, f5;

    int asserts = 0;
    int failures = 0;

    always #10 CLK = ~CLK;

    clock_splitter #(.HALF_PERIOD(1)) u_hp1 (
        .CLK(CLK), .reset(reset), .slowCLK(s1), .slow_rise(r1), .slow_fall(f1));
    clock_splitter #(.HALF_PERIOD(3)) u_hp3 (
        .CLK(CLK), .reset(reset), .slowCLK(s3), .slow_rise(r3), .slow_fall(f3));
    clock_splitter #(.HALF_PERIOD(4)) u_hp4 (
        .CLK(CLK), .reset(reset), .slowCLK(s4), .slow_rise(r4), .slow_fall(f4));
    clock_splitter #(.HALF_PERIOD(5)) u_hp5 (
        .CLK(CLK), .reset(reset), .slowCLK(s5), .slow_rise(r5), .slow_fall(f5));

    // Tuples are {slowCLK, slow_rise, slow_fall}.
    typedef struct packed {
        logic       rst;
        logic [2:0] e1;
        logic [2:0] e3;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    int high_cnt, low_cnt, rise_cnt, fall_cnt, both_cnt;
    logic [2:0] exp4;

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 3'b000, 3'b000};
        vecs[5]  = '{1'b0, 3'b110, 3'b000};
        vecs[6]  = '{1'b0, 3'b001, 3'b000};
        vecs[7]  = '{1'b0, 3'b110, 3'b110};
        vecs[8]  = '{1'b0, 3'b001, 3'b100};
        vecs[9]  = '{1'b0, 3'b110, 3'b100};
        vecs[10] = '{1'b0, 3'b001, 3'b001};
        vecs[11] = '{1'b0, 3'b110, 3'b000};
        vecs[12] = '{1'b0, 3'b001, 3'b000};
        vecs[13] = '{1'b0, 3'b110, 3'b110};
        vecs[14] = '{1'b0, 3'b001, 3'b100};
        vecs[15] = '{1'b0, 3'b110, 3'b100};
        vecs[16] = '{1'b0, 3'b001, 3'b001};
        vecs[17] = '{1'b0, 3'b110, 3'b000};
        vecs[18] = '{1'b0, 3'b001, 3'b000};

        // Reset for 5 cycles, then free-run HP1 and HP3 against the table.
        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst;
            step();
            check($sformatf("hp1_vec%0d", i), {9'b0, s1, r1, f1}, {9'b0, vecs[i].e1});
            check($sformatf("hp3_vec%0d", i), {9'b0, s3, r3, f3}, {9'b0, vecs[i].e3});
        end

        // HP5: reset in the 4th cycle of the high phase aborts the period.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("hp5_run%0d", k), {9'b0, s5, r5, f5},
                  {9'b0, (k < 5) ? 3'b000 : (k == 5) ? 3'b110 : 3'b100});
        end
        reset = 1'b1;
        step();
        check("hp5_mid_reset", {9'b0, s5, r5, f5}, 12'b0);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("hp5_rerun%0d", k), {9'b0, s5, r5, f5},
                  {9'b0, (k == 5) ? 3'b110 : 3'b000});
        end

        // Reset held 50 cycles: every output of every instance stays 0.
        reset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            check($sformatf("hold_reset%0d", k),
                  {s1, r1, f1, s3, r3, f3, s4, r4, f4, s5, r5, f5}, 12'b0);
        end

        // HP4 long run: per-cycle model plus scoreboard totals.
        reset = 1'b0;
        high_cnt = 0; low_cnt = 0; rise_cnt = 0; fall_cnt = 0; both_cnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            exp4 = {((k / 4) % 2) == 1, (k % 8) == 4, (k % 8) == 0};
            check($sformatf("hp4_cycle%0d", k), {9'b0, s4, r4, f4}, {9'b0, exp4});
            if (s4) high_cnt++; else low_cnt++;
            if (r4) rise_cnt++;
            if (f4) fall_cnt++;
            if (r4 && f4) both_cnt++;
        end
        check("hp4_high_count", 12'(high_cnt), 12'd500);
        check("hp4_low_count",  12'(low_cnt),  12'd500);
        check("hp4_rise_count", 12'(rise_cnt), 12'd125);
        check("hp4_fall_count", 12'(fall_cnt), 12'd125);
        check("hp4_coincide",   12'(both_cnt), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
